// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the program/data RAM arbiter.
// Holds the arbiter state encoding, the master identifier, default RAM
// geometry and the lock counter width.
package ram_arb_pkg;

    localparam int unsigned RAM_ADDR_W = 13;
    localparam int unsigned RAM_DATA_W = 32;
    localparam int unsigned LOCK_CNT_W = 8;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        LOCKED0 = 2'd1,
        LOCKED1 = 2'd2
    } arb_state_t;

    typedef enum logic {
        M_CORE = 1'b0,
        M_DMA  = 1'b1
    } master_id_t;

    // Locked state that belongs to a given master.
    function automatic arb_state_t locked_state(input master_id_t id);
        return (id == M_DMA) ? LOCKED1 : LOCKED0;
    endfunction

    // Identifier of the single master named by a one-hot grant vector.
    function automatic master_id_t gnt_id(input logic [1:0] gnt);
        return gnt[1] ? M_DMA : M_CORE;
    endfunction

endpackage

// File: rtl/ram_arb_rr2.sv
// Two-way round-robin grant logic with an allow mask.
//   clk, rst_n  : clock and asynchronous active-low reset
//   req         : request vector {M1, M0}
//   allow       : masters that may be granted this cycle (lock mask)
//   force_upd   : load rr_last with force_id (forced lock release, no grant)
//   force_id    : master to record as last owner on a forced release
//   gnt_c       : combinational one-hot grant
module ram_arb_rr2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] allow,
    input  logic       force_upd,
    input  master_id_t force_id,
    output logic [1:0] gnt_c
);

    master_id_t rr_last_q;
    logic [1:0] eff_req;

    assign eff_req = req & allow;

    // On a tie the master that was not granted last wins.
    always_comb begin
        gnt_c = 2'b00;
        unique case (eff_req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = (rr_last_q == M_DMA) ? 2'b01 : 2'b10;
            default: gnt_c = 2'b00;
        endcase
    end

    // Last owner: follows every grant, or is loaded on a forced release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= M_DMA;
        end else if (|gnt_c) begin
            rr_last_q <= gnt_id(gnt_c);
        end else if (force_upd) begin
            rr_last_q <= force_id;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter sharing the single-port program/data RAM between the core (M0)
// and the UART loader/DMA engine (M1). One access per cycle, round-robin
// on ties, optional bounded lock, read data routed back one cycle later
// to the master that issued the read.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   mX_req/we/lock/addr/wdata  : master X request payload
//   mX_gnt                     : access issued to RAM this cycle (combinational)
//   mX_rvalid/rdata            : read return, one cycle after the read grant
//   ram_addr/we/wdata/rdata    : RAM port (ram_rdata valid one cycle after address)
// Optional build macro RAM_ARB_STATS_EN adds stat_clr input and the
// stat_gnt0/stat_gnt1/stat_conflict/stat_force counters.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = RAM_ADDR_W,
    parameter int unsigned DATA_W   = RAM_DATA_W,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef RAM_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [31:0]       stat_gnt0,
    output logic [31:0]       stat_gnt1,
    output logic [31:0]       stat_conflict,
    output logic [15:0]       stat_force
`endif
);

    localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);
    localparam logic [LOCK_CNT_W-1:0] CNT_ONE    = LOCK_CNT_W'(1);

    arb_state_t              state_q, state_d;
    logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
    logic [LOCK_CNT_W-1:0]   cnt_inc_c;
    logic [1:0]              req_c;
    logic [1:0]              allow_c;
    logic [1:0]              gnt_c;
    logic                    any_gnt_c;
    logic                    gnt_lock_c;
    logic                    force_c;
    master_id_t              force_id_c;
    logic [1:0]              rd_pend_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       rdata0_q, rdata1_q;

    // Requests are masked while reset is asserted so no grant leaks out.
    assign req_c = {m1_req, m0_req} & {2{rst_n}};

    // Lock mask: only the owner may be granted while locked.
    always_comb begin
        allow_c = 2'b11;
        unique case (state_q)
            LOCKED0: allow_c = 2'b01;
            LOCKED1: allow_c = 2'b10;
            default: allow_c = 2'b11;
        endcase
    end

    ram_arb_rr2 u_rr2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_c),
        .allow     (allow_c),
        .force_upd (force_c),
        .force_id  (force_id_c),
        .gnt_c     (gnt_c)
    );

    assign any_gnt_c  = |gnt_c;
    assign gnt_lock_c = gnt_c[1] ? m1_lock : m0_lock;
    assign cnt_inc_c  = (lock_cnt_q == '1) ? lock_cnt_q : lock_cnt_q + CNT_ONE;

    assign m0_gnt = gnt_c[0];
    assign m1_gnt = gnt_c[1];

    // RAM port mux; address and write data hold their last value when idle.
    assign ram_addr  = any_gnt_c ? (gnt_c[1] ? m1_addr  : m0_addr)  : addr_q;
    assign ram_wdata = any_gnt_c ? (gnt_c[1] ? m1_wdata : m0_wdata) : wdata_q;
    assign ram_we    = any_gnt_c & (gnt_c[1] ? m1_we : m0_we);

    // Lock FSM next state. The grant that brings the count to MAX_LOCK is the
    // owner's last one; the arbiter is back in ARB the following cycle.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        force_c    = 1'b0;
        force_id_c = M_CORE;
        unique case (state_q)
            ARB: begin
                lock_cnt_d = '0;
                if (any_gnt_c && gnt_lock_c) begin
                    if (MAX_LOCK_C <= CNT_ONE) begin
                        force_c    = 1'b1;
                        force_id_c = gnt_id(gnt_c);
                    end else begin
                        state_d    = locked_state(gnt_id(gnt_c));
                        lock_cnt_d = CNT_ONE;
                    end
                end
            end
            LOCKED0, LOCKED1: begin
                if (any_gnt_c && !gnt_lock_c) begin
                    state_d    = ARB;
                    lock_cnt_d = '0;
                end else begin
                    // Idle cycles of the owner count toward the timeout too.
                    lock_cnt_d = cnt_inc_c;
                    if (cnt_inc_c >= MAX_LOCK_C) begin
                        state_d    = ARB;
                        lock_cnt_d = '0;
                        force_c    = 1'b1;
                        force_id_c = (state_q == LOCKED1) ? M_DMA : M_CORE;
                    end
                end
            end
            default: begin
                state_d    = ARB;
                lock_cnt_d = '0;
            end
        endcase
    end

    // FSM state and lock counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Hold registers for the idle RAM address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= ram_addr;
            wdata_q <= ram_wdata;
        end
    end

    // Read-return pipeline: one pending bit per master.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend_q <= 2'b00;
        end else begin
            rd_pend_q <= gnt_c & ~{m1_we, m0_we};
        end
    end

    assign m0_rvalid = rd_pend_q[0];
    assign m1_rvalid = rd_pend_q[1];

    // Returned data passes through in the rvalid cycle and is held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rd_pend_q[0]) rdata0_q <= ram_rdata;
            if (rd_pend_q[1]) rdata1_q <= ram_rdata;
        end
    end

    assign m0_rdata = rd_pend_q[0] ? ram_rdata : rdata0_q;
    assign m1_rdata = rd_pend_q[1] ? ram_rdata : rdata1_q;

`ifdef RAM_ARB_STATS_EN
    // Saturating statistics counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_gnt0     <= '0;
            stat_gnt1     <= '0;
            stat_conflict <= '0;
            stat_force    <= '0;
        end else if (stat_clr) begin
            stat_gnt0     <= '0;
            stat_gnt1     <= '0;
            stat_conflict <= '0;
            stat_force    <= '0;
        end else begin
            if (gnt_c[0] && (stat_gnt0 != '1))   stat_gnt0     <= stat_gnt0 + 32'd1;
            if (gnt_c[1] && (stat_gnt1 != '1))   stat_gnt1     <= stat_gnt1 + 32'd1;
            if ((&req_c) && (stat_conflict != '1)) stat_conflict <= stat_conflict + 32'd1;
            if (force_c && (stat_force != '1))   stat_force    <= stat_force + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 8K x 32
// synchronous-read RAM attached to the RAM port.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_lock;
    logic [12:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt, m0_rvalid;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we, m1_lock;
    logic [12:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
`ifdef RAM_ARB_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
    logic [15:0] stat_force;
`endif

    logic [31:0] mem [0:8191];
    int checks;
    int failures;

    ram_arbiter #(.ADDR_W(13), .DATA_W(32), .MAX_LOCK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
`ifdef RAM_ARB_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_gnt0     (stat_gnt0),
        .stat_gnt1     (stat_gnt1),
        .stat_conflict (stat_conflict),
        .stat_force    (stat_force)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with one-cycle synchronous read.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic l0,
                         input logic [12:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic l1,
                         input logic [12:0] a1, input logic [31:0] d1);
        m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 13'h0, 32'h0, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_m1;
        logic prev_m1;
        checks   = 0;
        failures = 0;
        mem[13'h0005] = 32'hDEADBEEF;
        mem[13'h0020] = 32'hA0A00020;
        mem[13'h0030] = 32'hB1B10030;
`ifdef RAM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif

        // Reset values, with M0 requesting to show grants stay low in reset.
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 13'h0123, 32'h12345678, 1'b1, 1'b0, 1'b0, 13'h0456, 32'h0);
        #1;
        chk("rst_gnt0", 32'(m0_gnt), 32'd0);
        chk("rst_gnt1", 32'(m1_gnt), 32'd0);
        chk("rst_rvalid0", 32'(m0_rvalid), 32'd0);
        chk("rst_rvalid1", 32'(m1_rvalid), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_rdata0", m0_rdata, 32'd0);
        chk("rst_rdata1", m1_rdata, 32'd0);
`ifdef RAM_ARB_STATS_EN
        chk("rst_stat_gnt0", stat_gnt0, 32'd0);
        chk("rst_stat_force", 32'(stat_force), 32'd0);
`endif
        idle();
        tick();
        rst_n = 1'b1;

        // Single master read of 0x0005.
        drive(1'b1, 1'b0, 1'b0, 13'h0005, 32'h0, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0);
        chk("single_gnt0", 32'(m0_gnt), 32'd1);
        chk("single_gnt1", 32'(m1_gnt), 32'd0);
        chk("single_addr", 32'(ram_addr), 32'h5);
        chk("single_we", 32'(ram_we), 32'd0);
        tick();
        idle();
        chk("single_rvalid0", 32'(m0_rvalid), 32'd1);
        chk("single_rdata0", m0_rdata, 32'hDEADBEEF);
        chk("single_rvalid1", 32'(m1_rvalid), 32'd0);
        chk("single_addr_hold", 32'(ram_addr), 32'h5);
        tick();
        chk("single_rvalid0_end", 32'(m0_rvalid), 32'd0);
        chk("single_rdata0_hold", m0_rdata, 32'hDEADBEEF);

        // Continuous conflict from reset: M0, M1, M0, M1, M0, M1.
        do_reset();
        prev_m1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, 13'h0020, 32'h0, 1'b1, 1'b0, 1'b0, 13'h0030, 32'h0);
            exp_m1 = (i % 2) == 1;
            chk($sformatf("conf_gnt0_%0d", i), 32'(m0_gnt), 32'(!exp_m1));
            chk($sformatf("conf_gnt1_%0d", i), 32'(m1_gnt), 32'(exp_m1));
            if (i > 0) begin
                chk($sformatf("conf_rvalid0_%0d", i), 32'(m0_rvalid), 32'(!prev_m1));
                chk($sformatf("conf_rvalid1_%0d", i), 32'(m1_rvalid), 32'(prev_m1));
                if (prev_m1) chk($sformatf("conf_rdata1_%0d", i), m1_rdata, 32'hB1B10030);
                else         chk($sformatf("conf_rdata0_%0d", i), m0_rdata, 32'hA0A00020);
            end
            prev_m1 = exp_m1;
            tick();
        end
        idle();
        chk("conf_last_rvalid1", 32'(m1_rvalid), 32'd1);
        chk("conf_last_rvalid0", 32'(m0_rvalid), 32'd0);
        chk("conf_last_rdata1", m1_rdata, 32'hB1B10030);
        tick();

        // Lock release: M0 write first so M1 wins the following tie.
        drive(1'b1, 1'b1, 1'b0, 13'h0100, 32'h11110100, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0);
        chk("lk_pre_gnt0", 32'(m0_gnt), 32'd1);
        chk("lk_pre_we", 32'(ram_we), 32'd1);
        chk("lk_pre_wdata", ram_wdata, 32'h11110100);
        tick();
        drive(1'b1, 1'b0, 1'b0, 13'h0005, 32'h0, 1'b1, 1'b1, 1'b1, 13'h1000, 32'hC0DE0000);
        chk("lk_c1_gnt1", 32'(m1_gnt), 32'd1);
        chk("lk_c1_gnt0", 32'(m0_gnt), 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 13'h0005, 32'h0, 1'b1, 1'b1, 1'b1, 13'h1001, 32'hC0DE0001);
        chk("lk_c2_gnt1", 32'(m1_gnt), 32'd1);
        chk("lk_c2_gnt0", 32'(m0_gnt), 32'd0);
        chk("lk_c2_addr", 32'(ram_addr), 32'h1001);
        tick();
        drive(1'b1, 1'b0, 1'b0, 13'h0005, 32'h0, 1'b1, 1'b1, 1'b0, 13'h1002, 32'hC0DE0002);
        chk("lk_c3_gnt1", 32'(m1_gnt), 32'd1);
        chk("lk_c3_gnt0", 32'(m0_gnt), 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 13'h0005, 32'h0, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0);
        chk("lk_c4_gnt0", 32'(m0_gnt), 32'd1);
        chk("lk_c4_addr", 32'(ram_addr), 32'h5);
        tick();
        idle();
        chk("lk_rvalid0", 32'(m0_rvalid), 32'd1);
        chk("lk_rdata0", m0_rdata, 32'hDEADBEEF);
        chk("lk_mem1000", mem[13'h1000], 32'hC0DE0000);
        chk("lk_mem1001", mem[13'h1001], 32'hC0DE0001);
        chk("lk_mem1002", mem[13'h1002], 32'hC0DE0002);
        chk("lk_mem0100", mem[13'h0100], 32'h11110100);
        tick();

        // Forced release: M0 keeps lock, M1 waits and wins on the 9th cycle.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 1'b1, 13'(32'h200 + i), 32'(32'h0D000000 + i),
                  (i >= 1), 1'b0, 1'b0, 13'h1000, 32'h0);
            chk($sformatf("frc_gnt0_%0d", i), 32'(m0_gnt), 32'(i < 8));
            chk($sformatf("frc_gnt1_%0d", i), 32'(m1_gnt), 32'(i == 8));
            tick();
        end
        idle();
        chk("frc_rvalid1", 32'(m1_rvalid), 32'd1);
        chk("frc_rdata1", m1_rdata, 32'hC0DE0000);
        chk("frc_mem0207", mem[13'h0207], 32'h0D000007);
`ifdef RAM_ARB_STATS_EN
        chk("frc_stat_force", 32'(stat_force), 32'd1);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        chk("clr_stat_force", 32'(stat_force), 32'd0);
        chk("clr_stat_gnt0", stat_gnt0, 32'd0);
`endif
        tick();

        // Reset in the cycle after an M0 read grant.
        drive(1'b1, 1'b0, 1'b0, 13'h0005, 32'h0, 1'b0, 1'b0, 1'b0, 13'h0, 32'h0);
        chk("rstrd_gnt0", 32'(m0_gnt), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstrd_rvalid0", 32'(m0_rvalid), 32'd0);
        chk("rstrd_gnt0_in_reset", 32'(m0_gnt), 32'd0);
        @(posedge clk);
        #1;
        chk("rstrd_rvalid0_next", 32'(m0_rvalid), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 13'h0020, 32'h0, 1'b1, 1'b0, 1'b0, 13'h0030, 32'h0);
        chk("rstrd_tie_gnt0", 32'(m0_gnt), 32'd1);
        chk("rstrd_tie_gnt1", 32'(m1_gnt), 32'd0);
        tick();
        idle();
        chk("rstrd_post_rvalid0", 32'(m0_rvalid), 32'd1);
        chk("rstrd_post_rdata0", m0_rdata, 32'hA0A00020);
        tick();

        // Reset while M1 holds a lock: the lock must not survive.
        drive(1'b0, 1'b0, 1'b0, 13'h0, 32'h0, 1'b1, 1'b1, 1'b1, 13'h0300, 32'h00000033);
        chk("rstlk_gnt1", 32'(m1_gnt), 32'd1);
        tick();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 13'h0020, 32'h0, 1'b1, 1'b1, 1'b0, 13'h0301, 32'h0);
        chk("rstlk_tie_gnt0", 32'(m0_gnt), 32'd1);
        chk("rstlk_tie_gnt1", 32'(m1_gnt), 32'd0);
        tick();
        idle();
        chk("rstlk_rvalid0", 32'(m0_rvalid), 32'd1);
        tick();

        // Idle bus for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("idle_we_%0d", i), 32'(ram_we), 32'd0);
            chk($sformatf("idle_gnt_%0d", i), 32'({m1_gnt, m0_gnt}), 32'd0);
            chk($sformatf("idle_rvalid_%0d", i), 32'({m1_rvalid, m0_rvalid}), 32'd0);
            chk($sformatf("idle_addr_%0d", i), 32'(ram_addr), 32'h0020);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
